// File: rtl/seg7_scan_ctrl.sv
// Bus-mapped 6-digit multiplexed seven-segment scanner with a blanking guard between digits.
// Optional leading-zero blanking is compiled in with `define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int DIV_CYC   = 125000,
  parameter int GUARD_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  seg_data,
  output logic [5:0]  seg_com
);

  localparam int CNT_MAX = (DIV_CYC > GUARD_CYC) ? DIV_CYC : GUARD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_DRIVE = 2'd1,
    S_GUARD = 2'd2
  } state_e;

  logic [23:0]      data_q;
  logic [5:0]       dots_q;
  logic             en_q;
  logic             lzb;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cur_digit_q, cur_digit_d;
  logic [7:0]       seg_data_q, seg_data_d;
  logic [5:0]       seg_com_q, seg_com_d;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = cs & we;
  assign unused_wdata = ^wdata[31:24];

  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  function automatic logic [3:0] nibble_sel(input logic [23:0] d, input logic [2:0] i);
    case (i)
      3'd0:    return d[3:0];
      3'd1:    return d[7:4];
      3'd2:    return d[11:8];
      3'd3:    return d[15:12];
      3'd4:    return d[19:16];
      3'd5:    return d[23:20];
      default: return 4'h0;
    endcase
  endfunction

  // Digit i is a leading zero when it and every more significant nibble are zero; digit 0 never is.
  function automatic logic lead_zero(input logic [23:0] d, input logic [2:0] i);
    case (i)
      3'd1:    return d[23:4]  == 20'h0;
      3'd2:    return d[23:8]  == 16'h0;
      3'd3:    return d[23:12] == 12'h0;
      3'd4:    return d[23:16] == 8'h0;
      3'd5:    return d[23:20] == 4'h0;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      dots_q <= '0;
      en_q   <= 1'b0;
    end else if (wr_en) begin
      case (addr)
        2'd0:    data_q <= wdata[23:0];
        2'd1:    dots_q <= wdata[5:0];
        2'd2:    en_q   <= wdata[0];
        default: ;
      endcase
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lzb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lzb_q <= 1'b0;
    end else if (wr_en && addr == 2'd2) begin
      lzb_q <= wdata[1];
    end
  end

  assign lzb = lzb_q;
`else
  assign lzb = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      cur_digit_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_digit_q <= cur_digit_d;
    end
  end

  // A cleared enable overrides every state, so re-enabling always starts at digit 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_digit_d = cur_digit_q;
    if (!en_q) begin
      state_d     = S_OFF;
      cnt_d       = '0;
      cur_digit_d = 3'd0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d     = S_DRIVE;
          cnt_d       = '0;
          cur_digit_d = 3'd0;
        end
        S_DRIVE: begin
          if (cnt_q == DIV_LAST) begin
            state_d = S_GUARD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d     = S_DRIVE;
            cnt_d       = '0;
            cur_digit_d = (cur_digit_q == 3'd5) ? 3'd0 : cur_digit_q + 3'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d     = S_OFF;
          cnt_d       = '0;
          cur_digit_d = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    seg_com_d  = 6'b111111;
    seg_data_d = 8'h00;
    if (state_q == S_DRIVE) begin
      seg_com_d     = ~(6'b000001 << cur_digit_q);
      seg_data_d[7] = dots_q[cur_digit_q];
      seg_data_d[6:0] = (lzb && lead_zero(data_q, cur_digit_q)) ? 7'h00
                                                                : hex7seg(nibble_sel(data_q, cur_digit_q));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_com_q  <= 6'b111111;
      seg_data_q <= 8'h00;
    end else begin
      seg_com_q  <= seg_com_d;
      seg_data_q <= seg_data_d;
    end
  end

  assign seg_com  = seg_com_q;
  assign seg_data = seg_data_q;

  always_comb begin
    rdata = 32'h0;
    if (cs) begin
      case (addr)
        2'd0:    rdata = {8'h00, data_q};
        2'd1:    rdata = {26'h0, dots_q};
        2'd2:    rdata = {30'h0, lzb, en_q};
        default: rdata = {26'h0, cur_digit_q, 1'b0, state_q};
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: register table, directed scan scenarios and random bus traffic,
// all checked cycle by cycle against a scan-position model.
module tb_seg7_scan_ctrl;

  localparam int DIV  = 8;
  localparam int GRD  = 2;
  localparam int SLOT = DIV + GRD;
  localparam int PER  = 6 * SLOT;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic LZB_ON = 1'b1;
`else
  localparam logic LZB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  seg_data;
  logic [5:0]  seg_com;

  int total = 0;
  int bad   = 0;

  // Model: m_age counts edges since the scan left OFF (0 = off); position in the scan is (m_age-1) mod PER.
  logic [23:0] m_data;
  logic [5:0]  m_dots;
  logic        m_en;
  logic        m_lzb;
  int          m_age;
  logic [7:0]  exp_data;
  logic [5:0]  exp_com;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] rb;
  } vec_t;
  vec_t vt[8];

  seg7_scan_ctrl #(.DIV_CYC(DIV), .GUARD_CYC(GRD)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .seg_data (seg_data),
    .seg_com  (seg_com)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int p;
    int dig;
    int st;
    if (m_age == 0) return 32'h0;
    p   = (m_age - 1) % PER;
    dig = p / SLOT;
    st  = ((p % SLOT) < DIV) ? 1 : 2;
    return {26'h0, 3'(dig), 1'b0, 2'(st)};
  endfunction

  task automatic model_reset();
    m_data = '0;
    m_dots = '0;
    m_en   = 1'b0;
    m_lzb  = 1'b0;
    m_age  = 0;
  endtask

  // Outputs after an edge reflect the scan position and registers as they stood before it.
  task automatic model_edge();
    int p;
    int dig;
    logic [23:0] upper;
    exp_com  = 6'h3F;
    exp_data = 8'h00;
    if (m_age > 0) begin
      p   = (m_age - 1) % PER;
      dig = p / SLOT;
      if ((p % SLOT) < DIV) begin
        exp_com     = 6'h3F & ~(6'(1) << dig);
        upper       = m_data >> (4 * dig);
        exp_data[7] = m_dots[dig];
        if (!(m_lzb && dig != 0 && upper == 24'h0))
          exp_data[6:0] = hex7(upper[3:0]);
      end
    end
    m_age = m_en ? m_age + 1 : 0;
    if (cs && we) begin
      case (addr)
        2'd0: m_data = wdata[23:0];
        2'd1: m_dots = wdata[5:0];
        2'd2: begin
          m_en = wdata[0];
          if (LZB_ON) m_lzb = wdata[1];
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("seg_com", {26'h0, seg_com}, {26'h0, exp_com});
    chk("seg_data", {24'h0, seg_data}, {24'h0, exp_data});
    cs    = 1'b1;
    we    = 1'b0;
    addr  = 2'd3;
    wdata = 32'h0;
    #1;
    chk("status", rdata, exp_status());
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs    = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic [1:0]  ra;
    logic [31:0] rd;

    vt[0] = '{2'd0, 32'hFFFF_FFFF, 32'h00FF_FFFF};
    vt[1] = '{2'd0, 32'h5A12_34AF, 32'h0012_34AF};
    vt[2] = '{2'd1, 32'hFFFF_FFC5, 32'h0000_0005};
    vt[3] = '{2'd1, 32'h0000_0000, 32'h0000_0000};
    vt[4] = '{2'd2, 32'hFFFF_FFFE, {30'h0, LZB_ON, 1'b0}};
    vt[5] = '{2'd2, 32'h0000_0000, 32'h0000_0000};
    vt[6] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[7] = '{2'd0, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1;
    cs    = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wdata = 32'h0;
    model_reset();

    // Reset held, then released with no writes: display stays dark.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_com", {26'h0, seg_com}, 32'h3F);
    chk("rst_data", {24'h0, seg_data}, 32'h0);
    chk("rst_rdata_cs0", rdata, 32'h0);
    reset = 1'b0;
    run(20);

    // Register write/readback table.
    for (int i = 0; i < 8; i++) begin
      wr(vt[i].a, vt[i].d);
      addr = vt[i].a;
      #1;
      chk($sformatf("regrd%0d", i), rdata, vt[i].rb);
    end
    cs = 1'b0;
    #1;
    chk("rd_cs0", rdata, 32'h0);

    // Scan of 0x1234AF: first lit digit two edges after the enable write.
    wr(2'd0, 32'h0012_34AF);
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h1);
    tick();
    chk("pre_first_com", {26'h0, seg_com}, 32'h3F);
    tick();
    chk("first_com", {26'h0, seg_com}, 32'h3E);
    chk("first_data", {24'h0, seg_data}, 32'h71);
    run(125);

    // Dots on digits 0 and 2.
    wr(2'd1, 32'h5);
    run(70);

    // Disable during digit 3 drive, then re-enable.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (m_age > 0 && ((m_age - 1) % PER) / SLOT == 3 && ((m_age - 1) % SLOT) < DIV - 2)
        found = 1'b1;
    end
    chk("wait_digit3", {31'h0, found}, 32'h1);
    wr(2'd2, 32'h0);
    tick();
    tick();
    chk("dis_blank_com", {26'h0, seg_com}, 32'h3F);
    chk("dis_blank_data", {24'h0, seg_data}, 32'h0);
    run(3);
    wr(2'd2, 32'h1);
    run(2);
    chk("reen_digit0", {26'h0, seg_com}, 32'h3E);
    run(20);

    // One-cycle reset in the first guard cycle, while the last digit is still lit.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (m_age > 0 && ((m_age - 1) % SLOT) == DIV) found = 1'b1;
    end
    chk("wait_guard", {31'h0, found}, 32'h1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_com", {26'h0, seg_com}, 32'h3F);
    chk("async_data", {24'h0, seg_data}, 32'h0);
    chk("async_status", rdata, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    addr  = 2'd0;
    #1;
    chk("post_rst_data", rdata, 32'h0);
    addr = 2'd2;
    #1;
    chk("post_rst_ctrl", rdata, 32'h0);
    run(30);
    wr(2'd2, 32'h1);
    run(70);

    // Leading-zero blanking patterns (blanking only takes effect when the option is built in).
    wr(2'd0, 32'h0000_0070);
    wr(2'd2, 32'h3);
    run(70);
    wr(2'd0, 32'h0);
    run(70);

    // Random bus traffic, mostly keeping the display enabled.
    repeat (900) begin
      if ($urandom_range(0, 7) == 0) begin
        ra = 2'($urandom_range(0, 3));
        rd = $urandom;
        if (ra == 2'd2) rd[0] = ($urandom_range(0, 9) != 0);
        wr(ra, rd);
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
